// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state type and the signed-overflow helper for alu_seq.
package alu_pkg;

  localparam logic [3:0] OP_ZERO = 4'd0;
  localparam logic [3:0] OP_AND  = 4'd1;
  localparam logic [3:0] OP_OR   = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_ADD  = 4'd4;
  localparam logic [3:0] OP_SUB  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_SAR  = 4'd8;
  localparam logic [3:0] OP_ROL  = 4'd9;
  localparam logic [3:0] OP_ROR  = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;

  typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_t;

  // Overflow when both addends share a sign and the sum's sign differs from it.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential unsigned shift-add multiplier: one partial product per cycle, W cycles per product.
module alu_mul_seq #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_start,
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic           o_done,
  output logic [2*W-1:0] o_product
);

  localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

  logic             r_busy;
  logic [CNT_W-1:0] r_cnt;
  logic [2*W-1:0]   r_acc;
  logic [2*W-1:0]   r_mcand;
  logic [W-1:0]     r_mplier;
  logic [2*W-1:0]   w_acc_nxt;

  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
  // The final step's sum is presented directly so the product lands on the same edge as done.
  assign o_done    = r_busy && (r_cnt == CNT_W'(W - 1));
  assign o_product = w_acc_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
    end else if (r_busy) begin
      if (o_done) r_busy <= 1'b0;
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_start) begin
      r_acc    <= '0;
      r_mcand  <= {{W{1'b0}}, i_a};
      r_mplier <= i_b;
    end else if (r_busy) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// W-bit registered ALU with valid/ready handshake and flags.
// ALU_MUL_EN enables the multi-cycle unsigned multiply (opcode 11); otherwise opcode 11 is illegal.
module alu_seq
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [3:0]     op,
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  input  logic           cin,
  output logic           out_valid,
  output logic [2*W-1:0] ans,
  output logic           carry,
  output logic           exceed,
  output logic           zero,
  output logic           neg,
  output logic           err
);

  localparam int SH_W = $clog2(W);

  state_t                r_state;
  logic                  w_accept;
  logic [SH_W-1:0]       w_amt;
  logic [W-1:0]          w_b;
  logic [W:0]            w_sum;
  logic signed [W-1:0]   w_xs;
  logic [2*W-1:0]        w_rotl;
  logic [2*W-1:0]        w_rotr;
  logic [2*W-1:0]        w_res;
  logic                  w_carry;
  logic                  w_exceed;
  logic                  w_err;
  logic                  w_mul_go;
  logic                  w_mul_done;
  logic [2*W-1:0]        w_mul_prod;

  assign in_ready = (r_state == IDLE);
  assign w_accept = in_valid && in_ready;
  assign w_amt    = y[SH_W-1:0];
  assign w_b      = (op == OP_SUB) ? ~y : y;
  assign w_sum    = {1'b0, x} + {1'b0, w_b} + {{W{1'b0}}, cin};
  assign w_xs     = x;
  // Rotates via a doubled operand: the wrapped bits fall out of the other half.
  assign w_rotl   = {x, x} << w_amt;
  assign w_rotr   = {x, x} >> w_amt;

`ifdef ALU_MUL_EN
  assign w_mul_go = w_accept && (op == OP_MUL);

  alu_mul_seq #(.W(W)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_mul_go),
    .i_a       (x),
    .i_b       (y),
    .o_done    (w_mul_done),
    .o_product (w_mul_prod)
  );
`else
  assign w_mul_go   = 1'b0;
  assign w_mul_done = 1'b0;
  assign w_mul_prod = '0;
`endif

  always_comb begin
    w_res    = '0;
    w_carry  = 1'b0;
    w_exceed = 1'b0;
    w_err    = 1'b0;
    case (op)
      OP_ZERO: w_res = '0;
      OP_AND:  w_res = {{W{1'b0}}, x & y};
      OP_OR:   w_res = {{W{1'b0}}, x | y};
      OP_XOR:  w_res = {{W{1'b0}}, x ^ y};
      OP_ADD, OP_SUB: begin
        w_res    = {{(W-1){1'b0}}, w_sum};
        w_carry  = w_sum[W];
        w_exceed = signed_ovf(x[W-1], w_b[W-1], w_sum[W-1]);
      end
      OP_SHL:  w_res = {{W{1'b0}}, x << w_amt};
      OP_SHR:  w_res = {{W{1'b0}}, x >> w_amt};
      OP_SAR:  w_res = {{W{1'b0}}, w_xs >>> w_amt};
      OP_ROL:  w_res = {{W{1'b0}}, w_rotl[2*W-1:W]};
      OP_ROR:  w_res = {{W{1'b0}}, w_rotr[W-1:0]};
`ifdef ALU_MUL_EN
      OP_MUL:  w_res = '0;
`endif
      default: w_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      out_valid <= 1'b0;
      ans       <= '0;
      carry     <= 1'b0;
      exceed    <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      err       <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_mul_go) begin
              r_state <= MUL;
            end else begin
              out_valid <= 1'b1;
              ans       <= w_res;
              carry     <= w_carry;
              exceed    <= w_exceed;
              zero      <= (w_res == '0);
              neg       <= w_res[W-1];
              err       <= w_err;
            end
          end
        end
        MUL: begin
          if (w_mul_done) begin
            r_state   <= IDLE;
            out_valid <= 1'b1;
            ans       <= w_mul_prod;
            carry     <= 1'b0;
            exceed    <= 1'b0;
            zero      <= (w_mul_prod == '0);
            neg       <= w_mul_prod[2*W-1];
            err       <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
